uart_prog_loader: RTL

Bus initiator that loads a program image into memory over the shared SoC bus while `programming` is high. It consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and issues one write transaction per word to `Mem_top`. The CPU core holds off the bus during programming, so this block is the sole initiator in that mode. After reset it is idle and drives no requests.

---
 rtl/uart_prog_loader_if.sv | 14 +
 rtl/uart_prog_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader_if.sv
// Shared SoC bus seen by the program loader: one write initiator, one responder.
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wrt_data;
    logic                  we;
    logic                  req_valid;
    logic                  data_valid;

    modport master (output addr, wrt_data, we, req_valid, input data_valid);
    modport slave  (input addr, wrt_data, we, req_valid, output data_valid);
endinterface

// File: rtl/uart_prog_loader.sv
// Loads a little-endian word image from the UART byte stream into memory,
// one bus write per assembled word, while programming is high.
module uart_prog_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               programming,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    uart_prog_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_written
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;
    localparam logic [31:0] TLIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [2:0]            state;
    logic [2:0]            bcnt;      // 4 means a complete word is buffered
    logic [31:0]           word_buf;
    logic [31:0]           rem;       // words still to be acknowledged
    logic [31:0]           tcnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_q;
    logic [15:0]           wcnt;

    logic [31:0] full_word;
    logic [4:0]  lane;
    logic        more;
    logic        collect;

    assign full_word = {rx_byte, word_buf[23:0]};
    assign lane      = {bcnt[1:0], 3'b000};
    assign more      = rem > 32'd1;
    // Bytes beyond the last image word are dropped rather than buffered.
    assign collect   = rx_valid && programming && more;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bcnt     <= '0;
            word_buf <= '0;
            rem      <= '0;
            tcnt     <= '0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            wcnt     <= '0;
        end else begin
            case (state)
                IDLE: if (programming) begin
                    state  <= HDR;
                    bcnt   <= '0;
                    addr_q <= BASE_ADDR;
                    wcnt   <= '0;
                end
                HDR: if (!programming) begin
                    state <= IDLE;
                end else if (rx_valid) begin
                    if (bcnt == 3'd3) begin
                        rem   <= full_word;
                        bcnt  <= '0;
                        state <= (full_word == 32'd0) ? DONE : DATA;
                    end else begin
                        word_buf[lane +: 8] <= rx_byte;
                        bcnt                <= bcnt + 3'd1;
                    end
                end
                DATA: if (!programming) begin
                    state <= IDLE;
                end else if (bcnt == 3'd4) begin
                    // Buffered word goes out one cycle after the previous ack.
                    wdata_q <= word_buf;
                    req_q   <= 1'b1;
                    tcnt    <= '0;
                    state   <= WAIT;
                    if (rx_valid) begin
                        word_buf[7:0] <= rx_byte;
                        bcnt          <= 3'd1;
                    end else begin
                        bcnt <= '0;
                    end
                end else if (rx_valid) begin
                    if (bcnt == 3'd3) begin
                        wdata_q <= full_word;
                        req_q   <= 1'b1;
                        tcnt    <= '0;
                        bcnt    <= '0;
                        state   <= WAIT;
                    end else begin
                        word_buf[lane +: 8] <= rx_byte;
                        bcnt                <= bcnt + 3'd1;
                    end
                end
                WAIT: if (bus.data_valid) begin
                    req_q  <= 1'b0;
                    wcnt   <= wcnt + 16'd1;
                    rem    <= rem - 32'd1;
                    addr_q <= addr_q + ADDR_WIDTH'(4);
                    if (!programming) state <= IDLE;
                    else if (!more)   state <= DONE;
                    else              state <= DATA;
                    if (collect) begin
                        if (bcnt == 3'd3) begin
                            word_buf <= full_word;
                            bcnt     <= 3'd4;
                        end else begin
                            word_buf[lane +: 8] <= rx_byte;
                            bcnt                <= bcnt + 3'd1;
                        end
                    end
                end else if (tcnt >= TLIM) begin
                    req_q <= 1'b0;
                    state <= ERR;
                end else begin
                    tcnt <= tcnt + 32'd1;
                    if (collect) begin
                        // A second full word with the first unacked has nowhere to go.
                        if (bcnt == 3'd3) begin
                            state <= ERR;
                        end else begin
                            word_buf[lane +: 8] <= rx_byte;
                            bcnt                <= bcnt + 3'd1;
                        end
                    end
                end
                DONE: if (!programming) state <= IDLE;
                ERR: if (req_q) begin
                    if (bus.data_valid) begin
                        req_q  <= 1'b0;
                        wcnt   <= wcnt + 16'd1;
                        addr_q <= addr_q + ADDR_WIDTH'(4);
                    end else if (tcnt >= TLIM) begin
                        req_q <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end else if (!programming) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr       = addr_q;
    assign bus.wrt_data   = wdata_q;
    assign bus.we         = req_q;
    assign bus.req_valid  = req_q;
    assign busy           = (state == HDR) || (state == DATA) || (state == WAIT);
    assign done           = (state == DONE);
    assign error          = (state == ERR);
    assign words_written  = wcnt;
endmodule
